// File: rtl/hbridge_pwm_gate.sv
// Avalon-MM controlled H-bridge PWM gate driver with dead-time insertion between mode changes.
// Define HBRIDGE_FAULT_EN to add the coe_FAULT input and the sticky fault latch in STATUS bit3.
module hbridge_pwm_gate (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [2:0]  avs_ctrl_address,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   input  logic [31:0] avs_ctrl_writedata,
   input  logic [3:0]  avs_ctrl_byteenable,
   output logic [31:0] avs_ctrl_readdata,
   output logic        avs_ctrl_waitrequest,
`ifdef HBRIDGE_FAULT_EN
   input  logic        coe_FAULT,
`endif
   output logic        HX_H,
   output logic        HX_L,
   output logic        HY_H,
   output logic        HY_L
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StDrive = 2'b01,
      StDead  = 2'b10,
      StBrake = 2'b11
   } state_e;

   localparam logic [31:0] IdValue = 32'hEA680003;

   logic [2:0]  ctrl_q;
   logic [15:0] period_q;
   logic [15:0] duty_q;
   logic [7:0]  deadtime_q;
   logic        fault_q;
   logic        fault_now;
   state_e      state_q;
   state_e      target;
   logic        dir_q;
   logic [7:0]  dead_cnt_q;
   logic [15:0] cnt_q;
   logic [15:0] per_sh_q;
   logic [15:0] duty_sh_q;
   logic [15:0] per_eff;
   logic        wrap;
   logic        pwm;
   logic [31:0] rd_data;
   logic        wr_lane0;
   logic        unused_bits;

   assign avs_ctrl_waitrequest = 1'b0;
   assign wr_lane0    = avs_ctrl_write & avs_ctrl_byteenable[0];
   assign unused_bits = ^{avs_ctrl_writedata[31:16], avs_ctrl_byteenable[3:2]};

`ifdef HBRIDGE_FAULT_EN
   // Set wins over a simultaneous clear so a live fault can never be acknowledged away.
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         fault_q <= 1'b0;
      end else if (coe_FAULT) begin
         fault_q <= 1'b1;
      end else if (wr_lane0 && avs_ctrl_address == 3'd4 && avs_ctrl_writedata[3]) begin
         fault_q <= 1'b0;
      end
   end
   assign fault_now = coe_FAULT | fault_q;
`else
   assign fault_q   = 1'b0;
   assign fault_now = 1'b0;
`endif

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         ctrl_q     <= 3'd0;
         period_q   <= 16'd1000;
         duty_q     <= 16'd0;
         deadtime_q <= 8'd16;
      end else if (avs_ctrl_write) begin
         case (avs_ctrl_address)
            3'd0: if (avs_ctrl_byteenable[0]) ctrl_q <= avs_ctrl_writedata[2:0];
            3'd1: begin
               if (avs_ctrl_byteenable[0]) period_q[7:0]  <= avs_ctrl_writedata[7:0];
               if (avs_ctrl_byteenable[1]) period_q[15:8] <= avs_ctrl_writedata[15:8];
            end
            3'd2: begin
               if (avs_ctrl_byteenable[0]) duty_q[7:0]  <= avs_ctrl_writedata[7:0];
               if (avs_ctrl_byteenable[1]) duty_q[15:8] <= avs_ctrl_writedata[15:8];
            end
            3'd3: if (avs_ctrl_byteenable[0]) deadtime_q <= avs_ctrl_writedata[7:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data = 32'd0;
      case (avs_ctrl_address)
         3'd0: rd_data[2:0]  = ctrl_q;
         3'd1: rd_data[15:0] = period_q;
         3'd2: rd_data[15:0] = duty_q;
         3'd3: rd_data[7:0]  = deadtime_q;
         3'd4: begin
            rd_data[1:0] = state_q;
            rd_data[3]   = fault_q;
         end
         3'd5: rd_data = IdValue;
         default: ;
      endcase
   end

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         avs_ctrl_readdata <= 32'd0;
      end else if (avs_ctrl_read) begin
         avs_ctrl_readdata <= rd_data;
      end
   end

   always_comb begin
      if (!ctrl_q[0] || fault_now) begin
         target = StIdle;
      end else if (ctrl_q[2]) begin
         target = StBrake;
      end else begin
         target = StDrive;
      end
   end

   assign per_eff = (per_sh_q < 16'd2) ? 16'd2 : per_sh_q;
   assign wrap    = (cnt_q >= per_eff - 16'd1);
   assign pwm     = (cnt_q < duty_sh_q);

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         state_q    <= StIdle;
         dir_q      <= 1'b0;
         dead_cnt_q <= 8'd0;
         cnt_q      <= 16'd0;
         per_sh_q   <= 16'd0;
         duty_sh_q  <= 16'd0;
         HX_H       <= 1'b0;
         HX_L       <= 1'b0;
         HY_H       <= 1'b0;
         HY_L       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (target != StIdle) begin
                  state_q    <= StDead;
                  dead_cnt_q <= deadtime_q;
               end
            end
            StDrive: begin
               if (target == StIdle) begin
                  state_q <= StIdle;
               end else if (target == StBrake || ctrl_q[1] != dir_q) begin
                  state_q    <= StDead;
                  dead_cnt_q <= deadtime_q;
               end else if (wrap) begin
                  cnt_q     <= 16'd0;
                  per_sh_q  <= period_q;
                  duty_sh_q <= duty_q;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StBrake: begin
               if (target == StIdle) begin
                  state_q <= StIdle;
               end else if (target == StDrive) begin
                  state_q    <= StDead;
                  dead_cnt_q <= deadtime_q;
               end
            end
            StDead: begin
               if (target == StIdle) begin
                  state_q <= StIdle;
               end else if (dead_cnt_q == 8'd0) begin
                  state_q <= target;
                  if (target == StDrive) begin
                     dir_q     <= ctrl_q[1];
                     cnt_q     <= 16'd0;
                     per_sh_q  <= period_q;
                     duty_sh_q <= duty_q;
                  end
               end else begin
                  dead_cnt_q <= dead_cnt_q - 8'd1;
               end
            end
         endcase

         // A pending IDLE target blanks the gates on this update rather than one state later.
         HX_H <= 1'b0;
         HX_L <= 1'b0;
         HY_H <= 1'b0;
         HY_L <= 1'b0;
         if (target != StIdle) begin
            if (state_q == StBrake) begin
               HX_L <= 1'b1;
               HY_L <= 1'b1;
            end else if (state_q == StDrive) begin
               if (dir_q) begin
                  HX_H <= pwm;
                  HY_L <= 1'b1;
               end else begin
                  HY_H <= pwm;
                  HX_L <= 1'b1;
               end
            end
         end
      end
   end

endmodule
